player_input_ctrl: RTL and testbench
====================================

PLAYER_INPUT_CTRL -- requirements
Module: player_input_ctrl

Interface
REQ-001 Parameter BOMB_COOLDOWN, default 8: number of frame ticks after an accepted bomb request during which further bomb requests from the same player are ignored.
REQ-002 Clk  input  1  system clock, 50 MHz (CLOCK_50).
REQ-003 Reset_n  input  1  reset; asynchronous, active-low.
REQ-004 keycode  input  16  USB HID keycodes from the Nios PIO; slot A = [7:0], slot B = [15:8]; 0x00 = empty slot.
REQ-005 frame_clk  input  1  VGA vertical sync; asynchronous to Clk.
REQ-006 frame_tick  output  1  one-Clk pulse per frame_clk rising edge.
REQ-007 p1_dir, p2_dir  output  2 each  latched direction: 0=up, 1=down, 2=left, 3=right.
REQ-008 p1_move, p2_move  output  1 each  one-Clk pulse: move one step in the matching pN_dir.
REQ-009 p1_bomb, p2_bomb  output  1 each  one-Clk bomb-placement request pulse.
REQ-010 paused  output  1  level; high while the game is paused.

Function
REQ-011 frame_clk SHALL pass through a 2-flop synchronizer.
REQ-012 frame_tick SHALL assert for one cycle on the synchronized 0->1 edge, 3 Clk cycles after the raw edge.
REQ-013 A key SHALL count as held when either keycode slot equals its code.
REQ-014 Key map: P1 up/down/left/right = 0x1A/0x16/0x04/0x07, P1 bomb = 0x2C; P2 = 0x52/0x51/0x50/0x4F, P2 bomb = 0x28; pause = 0x29.
REQ-015 The held state SHALL be registered once per Clk into a key-state vector; the previous-cycle copy SHALL be kept for edge detection.
REQ-016 Direction resolution per player: up+down both held cancels vertical; left+right both held cancels horizontal.
REQ-017 After cancellation, direction priority SHALL be up > down > left > right.
REQ-018 On frame_tick with a resolved direction and paused=0, pN_dir SHALL load that direction and pN_move SHALL pulse in the same cycle (registered, 1 cycle after frame_tick).
REQ-019 If no direction resolves, pN_move SHALL stay 0 and pN_dir SHALL hold its last value.
REQ-020 Bomb FSM per player has two states: READY and COOLDOWN.
REQ-021 In READY, a held 0->1 edge on the bomb key with paused=0 SHALL pulse pN_bomb for exactly one cycle, load the cooldown counter with BOMB_COOLDOWN and enter COOLDOWN.
REQ-022 In COOLDOWN, the counter SHALL decrement on each frame_tick; at 0 the FSM SHALL return to READY, and bomb edges during COOLDOWN SHALL be discarded, not queued.
REQ-023 Holding the bomb key SHALL produce only one pulse; a new pulse needs release then re-press.
REQ-024 The cooldown counter SHALL be width $clog2(BOMB_COOLDOWN+1) and SHALL never underflow.
REQ-025 The two players' FSMs SHALL be independent, and simultaneous edges SHALL yield simultaneous pulses.
REQ-026 A 0->1 edge of the pause key SHALL toggle paused.
REQ-027 While paused=1, pN_move and pN_bomb SHALL be 0, and cooldown counters SHALL freeze.
REQ-028 Edges occurring while paused SHALL be discarded.
REQ-029 Unmapped keycodes SHALL be ignored.
REQ-030 Identical codes in both slots SHALL be treated as one held key.

Reset
REQ-031 Reset_n=0 SHALL immediately (asynchronously) clear all outputs to 0, both FSMs to READY, both counters to 0, paused to 0, the synchronizer flops to 0, and both key-state vectors to 0.
REQ-032 Reset asserted mid-cooldown SHALL abandon the cooldown.
REQ-033 A key already held when Reset_n releases SHALL register as a new edge on the first sampled cycle.

Verification
REQ-034 Held 0x1A in slot A, 3 frame_clk edges -> 3 p1_move pulses, each with p1_dir=0, each 4 Clk after its raw edge; p2_move stays 0.
REQ-035 keycode=0x1604 (S+A) -> p1_dir=1 on the next tick; keycode=0x1A16 (W+S) -> no p1_move and p1_dir unchanged.
REQ-036 Hold 0x2C for 20 frames -> exactly one p1_bomb pulse; release, re-press at frame 5 of cooldown -> no pulse; re-press after 8 ticks -> one pulse.
REQ-037 keycode=0x282C in one cycle -> p1_bomb and p2_bomb pulse in the same cycle.
REQ-038 Press-release 0x29 -> paused=1; held 0x52 across 4 ticks -> no p2_move; press 0x29 again -> paused=0 and moves resume on the next tick.
REQ-039 Reset_n pulled low mid-cooldown while p1_move is high -> outputs 0 in the same cycle; after release, a 0x2C press -> immediate p1_bomb.

Source files
------------

// File: rtl/player_input_ctrl.sv
// -----------------------------------------------------------------------------
// player_input_ctrl
//   Turns the USB keyboard keycodes delivered by the Nios PIO into per-frame
//   game actions for two players: latched movement directions with one-cycle
//   move pulses, rate-limited bomb requests and a pause toggle.
//
// Ports
//   Clk          in   1   system clock (50 MHz)
//   Reset_n      in   1   asynchronous active-low reset
//   keycode      in  16   two HID keycode slots, [7:0] and [15:8], 0x00 = empty
//   frame_clk    in   1   VGA vertical sync, asynchronous to Clk
//   frame_tick   out  1   one-Clk pulse per synchronized frame_clk rising edge
//   p1_dir       out  2   player 1 latched direction (0 up, 1 down, 2 left, 3 right)
//   p2_dir       out  2   player 2 latched direction
//   p1_move      out  1   player 1 one-step move pulse
//   p2_move      out  1   player 2 one-step move pulse
//   p1_bomb      out  1   player 1 bomb placement pulse
//   p2_bomb      out  1   player 2 bomb placement pulse
//   paused       out  1   high while the game is paused
// -----------------------------------------------------------------------------
module player_input_ctrl #(
    parameter int BOMB_COOLDOWN = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] keycode,
    input  logic        frame_clk,
    output logic        frame_tick,
    output logic [1:0]  p1_dir,
    output logic [1:0]  p2_dir,
    output logic        p1_move,
    output logic        p2_move,
    output logic        p1_bomb,
    output logic        p2_bomb,
    output logic        paused
);

    // A zero cooldown would give a zero-width counter; keep at least one bit.
    localparam int CNT_W = ($clog2(BOMB_COOLDOWN + 1) < 1) ? 1 : $clog2(BOMB_COOLDOWN + 1);

    // Bit positions inside the key-state vector.
    localparam int K_P1_UP   = 0;
    localparam int K_P1_DN   = 1;
    localparam int K_P1_LT   = 2;
    localparam int K_P1_RT   = 3;
    localparam int K_P1_BOMB = 4;
    localparam int K_P2_UP   = 5;
    localparam int K_P2_DN   = 6;
    localparam int K_P2_LT   = 7;
    localparam int K_P2_RT   = 8;
    localparam int K_P2_BOMB = 9;
    localparam int K_PAUSE   = 10;
    localparam int NKEYS     = 11;

    localparam logic [1:0] DIR_UP = 2'd0;
    localparam logic [1:0] DIR_DN = 2'd1;
    localparam logic [1:0] DIR_LT = 2'd2;
    localparam logic [1:0] DIR_RT = 2'd3;

    typedef enum logic {
        BOMB_READY = 1'b0,
        BOMB_WAIT  = 1'b1
    } bomb_state_t;

    // A key is held when either slot carries its code; duplicates collapse.
    function automatic logic key_held(input logic [15:0] kc, input logic [7:0] code);
        return (kc[7:0] == code) || (kc[15:8] == code);
    endfunction

    // Opposing keys cancel, then up > down > left > right. Result is {valid, dir}.
    function automatic logic [2:0] resolve_dir(input logic [3:0] udlr);
        logic       up_s;
        logic       dn_s;
        logic       lt_s;
        logic       rt_s;
        logic [2:0] res_s;
        up_s = udlr[0] & ~udlr[1];
        dn_s = udlr[1] & ~udlr[0];
        lt_s = udlr[2] & ~udlr[3];
        rt_s = udlr[3] & ~udlr[2];
        if (up_s) begin
            res_s = {1'b1, DIR_UP};
        end else if (dn_s) begin
            res_s = {1'b1, DIR_DN};
        end else if (lt_s) begin
            res_s = {1'b1, DIR_LT};
        end else if (rt_s) begin
            res_s = {1'b1, DIR_RT};
        end else begin
            res_s = 3'b000;
        end
        return res_s;
    endfunction

    logic               sync1_r;
    logic               sync2_r;
    logic               sync3_r;
    logic               frame_tick_r;
    logic [NKEYS-1:0]   keys_s;
    logic [NKEYS-1:0]   key_r;
    logic [NKEYS-1:0]   key_prev_r;
    logic [NKEYS-1:0]   key_edge_s;
    logic               paused_r;
    logic               paused_nxt_s;
    logic               active_s;
    logic [2:0]         p1_res_s;
    logic [2:0]         p2_res_s;
    logic [1:0]         p1_dir_r;
    logic [1:0]         p2_dir_r;
    logic               p1_move_r;
    logic               p2_move_r;
    logic [1:0]         bomb_edge_s;
    logic [1:0]         bomb_go_s;
    logic               p1_bomb_r;
    logic               p2_bomb_r;
    bomb_state_t        state_r     [2];
    bomb_state_t        state_nxt_s [2];
    logic [CNT_W-1:0]   cnt_r       [2];
    logic [CNT_W-1:0]   cnt_nxt_s   [2];

    // Two-flop synchronizer for frame_clk plus a delay flop for edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_r      <= 1'b0;
            sync2_r      <= 1'b0;
            sync3_r      <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            sync1_r      <= frame_clk;
            sync2_r      <= sync1_r;
            sync3_r      <= sync2_r;
            frame_tick_r <= sync2_r & ~sync3_r;
        end
    end

    // Decode both keycode slots into the held-key vector.
    always_comb begin
        keys_s            = '0;
        keys_s[K_P1_UP]   = key_held(keycode, 8'h1A);
        keys_s[K_P1_DN]   = key_held(keycode, 8'h16);
        keys_s[K_P1_LT]   = key_held(keycode, 8'h04);
        keys_s[K_P1_RT]   = key_held(keycode, 8'h07);
        keys_s[K_P1_BOMB] = key_held(keycode, 8'h2C);
        keys_s[K_P2_UP]   = key_held(keycode, 8'h52);
        keys_s[K_P2_DN]   = key_held(keycode, 8'h51);
        keys_s[K_P2_LT]   = key_held(keycode, 8'h50);
        keys_s[K_P2_RT]   = key_held(keycode, 8'h4F);
        keys_s[K_P2_BOMB] = key_held(keycode, 8'h28);
        keys_s[K_PAUSE]   = key_held(keycode, 8'h29);
    end

    // Key-state vector and its previous-cycle copy. Both clear on reset, so a
    // key held through reset release shows up as a fresh press.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_r      <= '0;
            key_prev_r <= '0;
        end else begin
            key_r      <= keys_s;
            key_prev_r <= key_r;
        end
    end

    // Press edges, next pause level and direction resolution. Gameplay is
    // gated by the pause level being entered this cycle, so the cycle in which
    // pause engages already suppresses moves/bombs and discards edges.
    always_comb begin
        key_edge_s   = key_r & ~key_prev_r;
        paused_nxt_s = paused_r ^ key_edge_s[K_PAUSE];
        active_s     = ~paused_nxt_s;
        bomb_edge_s  = {key_edge_s[K_P2_BOMB], key_edge_s[K_P1_BOMB]};
        p1_res_s     = resolve_dir({key_r[K_P1_RT], key_r[K_P1_LT], key_r[K_P1_DN], key_r[K_P1_UP]});
        p2_res_s     = resolve_dir({key_r[K_P2_RT], key_r[K_P2_LT], key_r[K_P2_DN], key_r[K_P2_UP]});
    end

    // Pause level register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            paused_r <= 1'b0;
        end else begin
            paused_r <= paused_nxt_s;
        end
    end

    // Per-frame movement: load the direction and pulse move together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            p1_dir_r  <= 2'd0;
            p2_dir_r  <= 2'd0;
            p1_move_r <= 1'b0;
            p2_move_r <= 1'b0;
        end else begin
            p1_move_r <= 1'b0;
            p2_move_r <= 1'b0;
            if (frame_tick_r && active_s && p1_res_s[2]) begin
                p1_dir_r  <= p1_res_s[1:0];
                p1_move_r <= 1'b1;
            end else begin
                p1_dir_r  <= p1_dir_r;
            end
            if (frame_tick_r && active_s && p2_res_s[2]) begin
                p2_dir_r  <= p2_res_s[1:0];
                p2_move_r <= 1'b1;
            end else begin
                p2_dir_r  <= p2_dir_r;
            end
        end
    end

    // Bomb FSM next-state: READY fires on a press edge; WAIT counts frame
    // ticks down and returns to READY when the count is spent.
    always_comb begin
        bomb_go_s = 2'b00;
        for (int p = 0; p < 2; p++) begin
            state_nxt_s[p] = state_r[p];
            cnt_nxt_s[p]   = cnt_r[p];
            case (state_r[p])
                BOMB_READY: begin
                    if (bomb_edge_s[p] && active_s) begin
                        bomb_go_s[p]   = 1'b1;
                        cnt_nxt_s[p]   = CNT_W'(BOMB_COOLDOWN);
                        state_nxt_s[p] = BOMB_WAIT;
                    end else begin
                        state_nxt_s[p] = BOMB_READY;
                    end
                end
                BOMB_WAIT: begin
                    if (frame_tick_r && active_s) begin
                        // Saturate at zero rather than wrap.
                        if (cnt_r[p] <= CNT_W'(1)) begin
                            cnt_nxt_s[p]   = '0;
                            state_nxt_s[p] = BOMB_READY;
                        end else begin
                            cnt_nxt_s[p]   = cnt_r[p] - CNT_W'(1);
                        end
                    end else begin
                        state_nxt_s[p] = BOMB_WAIT;
                    end
                end
                default: begin
                    state_nxt_s[p] = BOMB_READY;
                    cnt_nxt_s[p]   = '0;
                end
            endcase
        end
    end

    // Bomb FSM state, counters and registered bomb pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < 2; p++) begin
                state_r[p] <= BOMB_READY;
                cnt_r[p]   <= '0;
            end
            p1_bomb_r <= 1'b0;
            p2_bomb_r <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_r[p] <= state_nxt_s[p];
                cnt_r[p]   <= cnt_nxt_s[p];
            end
            p1_bomb_r <= bomb_go_s[0];
            p2_bomb_r <= bomb_go_s[1];
        end
    end

    assign frame_tick = frame_tick_r;
    assign p1_dir     = p1_dir_r;
    assign p2_dir     = p2_dir_r;
    assign p1_move    = p1_move_r;
    assign p2_move    = p2_move_r;
    assign p1_bomb    = p1_bomb_r;
    assign p2_bomb    = p2_bomb_r;
    assign paused     = paused_r;

endmodule

// File: tb/tb_player_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_input_ctrl
//   Self-checking bench for player_input_ctrl. A small behavioural model tracks
//   held keys, pause level, latched directions and remaining cooldown ticks per
//   player, and predicts each frame's moves and each key change's bomb pulses.
// -----------------------------------------------------------------------------
module tb_player_input_ctrl;

    localparam int BC = 8;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] keycode;
    logic        frame_clk;
    logic        frame_tick;
    logic [1:0]  p1_dir;
    logic [1:0]  p2_dir;
    logic        p1_move;
    logic        p2_move;
    logic        p1_bomb;
    logic        p2_bomb;
    logic        paused;

    int checks = 0;
    int errors = 0;

    // Model state. Held-key vector layout: P1 up,down,left,right,bomb = 0..4,
    // P2 up,down,left,right,bomb = 5..9, pause = 10.
    logic [10:0] m_prev;
    logic        m_paused;
    int          m_cd  [2];
    logic [1:0]  m_dir [2];

    player_input_ctrl #(.BOMB_COOLDOWN(BC)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick),
        .p1_dir     (p1_dir),
        .p2_dir     (p2_dir),
        .p1_move    (p1_move),
        .p2_move    (p2_move),
        .p1_bomb    (p1_bomb),
        .p2_bomb    (p2_bomb),
        .paused     (paused)
    );

    always #10 Clk = ~Clk;

    function automatic logic [7:0] code_of(input int i);
        case (i)
            0:       return 8'h1A;
            1:       return 8'h16;
            2:       return 8'h04;
            3:       return 8'h07;
            4:       return 8'h2C;
            5:       return 8'h52;
            6:       return 8'h51;
            7:       return 8'h50;
            8:       return 8'h4F;
            9:       return 8'h28;
            default: return 8'h29;
        endcase
    endfunction

    function automatic logic [10:0] decode(input logic [15:0] kc);
        logic [10:0] h;
        h = '0;
        for (int i = 0; i < 11; i++) begin
            h[i] = (kc[7:0] == code_of(i)) || (kc[15:8] == code_of(i));
        end
        return h;
    endfunction

    // Net vertical/horizontal intent; returns direction or -1 when none.
    function automatic int resolve(input logic u, input logic d, input logic l, input logic r);
        int v;
        int h;
        v = int'(d) - int'(u);
        h = int'(r) - int'(l);
        if (v < 0) return 0;
        if (v > 0) return 1;
        if (h < 0) return 2;
        if (h > 0) return 3;
        return -1;
    endfunction

    function automatic logic [7:0] rand_code();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1, 2:    return code_of(int'($urandom_range(0, 10)));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic model_reset();
        m_prev   = '0;
        m_paused = 1'b0;
        m_cd[0]  = 0;
        m_cd[1]  = 0;
        m_dir[0] = 2'd0;
        m_dir[1] = 2'd0;
    endtask

    // Predict and check the DUT response to keycode having just changed to kc.
    task automatic check_key_response(input logic [15:0] kc);
        logic [10:0] held;
        logic [10:0] edges;
        logic [1:0]  exp_b;
        held   = decode(kc);
        edges  = held & ~m_prev;
        m_prev = held;
        if (edges[10]) m_paused = ~m_paused;
        for (int p = 0; p < 2; p++) begin
            exp_b[p] = edges[p*5+4] && !m_paused && (m_cd[p] == 0);
            if (exp_b[p]) m_cd[p] = BC;
        end
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if ({p2_bomb, p1_bomb} !== ((cyc == 2) ? exp_b : 2'b00)) begin
                errors++;
                $display("FAIL bomb_pulse kc=%h cyc=%0d got=%b exp=%b", kc, cyc, {p2_bomb, p1_bomb}, (cyc == 2) ? exp_b : 2'b00);
            end
            checks++;
            if ({p2_move, p1_move} !== 2'b00) begin
                errors++;
                $display("FAIL move_on_key kc=%h cyc=%0d got=%b exp=00", kc, cyc, {p2_move, p1_move});
            end
        end
        checks++;
        if (paused !== m_paused) begin
            errors++;
            $display("FAIL paused kc=%h got=%b exp=%b", kc, paused, m_paused);
        end
    endtask

    task automatic apply_keys(input logic [15:0] kc);
        @(negedge Clk);
        keycode = kc;
        check_key_response(kc);
    endtask

    // One frame_clk rising edge; optionally pull reset while the move pulse is up.
    task automatic do_frame(input bit rst_at_move);
        int   d      [2];
        logic exp_mv [2];
        for (int p = 0; p < 2; p++) begin
            d[p]      = resolve(m_prev[p*5+0], m_prev[p*5+1], m_prev[p*5+2], m_prev[p*5+3]);
            exp_mv[p] = !m_paused && (d[p] >= 0);
        end
        @(negedge Clk);
        frame_clk = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge Clk);
            @(negedge Clk);
            checks++;
            if (frame_tick !== (cyc == 3)) begin
                errors++;
                $display("FAIL frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, (cyc == 3));
            end
            if (cyc < 4) begin
                checks++;
                if ({p2_move, p1_move} !== 2'b00) begin
                    errors++;
                    $display("FAIL move_early cyc=%0d got=%b exp=00", cyc, {p2_move, p1_move});
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (exp_mv[p]) m_dir[p] = 2'(d[p]);
            if (!m_paused && m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
        end
        checks++;
        if ({p2_move, p1_move} !== {exp_mv[1], exp_mv[0]}) begin
            errors++;
            $display("FAIL move_pulse got=%b exp=%b", {p2_move, p1_move}, {exp_mv[1], exp_mv[0]});
        end
        checks++;
        if ({p2_dir, p1_dir} !== {m_dir[1], m_dir[0]}) begin
            errors++;
            $display("FAIL dir got=%h/%h exp=%h/%h", p1_dir, p2_dir, m_dir[0], m_dir[1]);
        end
        checks++;
        if ({p2_bomb, p1_bomb} !== 2'b00) begin
            errors++;
            $display("FAIL bomb_on_frame got=%b exp=00", {p2_bomb, p1_bomb});
        end
        if (rst_at_move) begin
            Reset_n   = 1'b0;
            frame_clk = 1'b0;
            #1;
            checks++;
            if ({frame_tick, p1_dir, p2_dir, p1_move, p2_move, p1_bomb, p2_bomb, paused} !== 10'b0) begin
                errors++;
                $display("FAIL async_reset got=%b exp=0", {frame_tick, p1_dir, p2_dir, p1_move, p2_move, p1_bomb, p2_bomb, paused});
            end
            model_reset();
        end else begin
            @(negedge Clk);
            frame_clk = 1'b0;
            for (int cyc = 1; cyc <= 3; cyc++) begin
                @(posedge Clk);
                @(negedge Clk);
                checks++;
                if (frame_tick !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_tick_fall cyc=%0d got=%b exp=0", cyc, frame_tick);
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        keycode   = 16'h0000;
        frame_clk = 1'b0;
        model_reset();
        #35;
        checks++;
        if ({frame_tick, p1_dir, p2_dir, p1_move, p2_move, p1_bomb, p2_bomb, paused} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=0", {frame_tick, p1_dir, p2_dir, p1_move, p2_move, p1_bomb, p2_bomb, paused});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_move();
        apply_keys(16'h001A);
        repeat (3) do_frame(1'b0);
    endtask

    task automatic test_resolve();
        apply_keys(16'h1604);
        do_frame(1'b0);
        checks++;
        if (p1_dir !== 2'd1) begin
            errors++;
            $display("FAIL s_plus_a_dir got=%0d exp=1", p1_dir);
        end
        apply_keys(16'h1A16);
        do_frame(1'b0);
        apply_keys(16'h0407);
        do_frame(1'b0);
    endtask

    task automatic test_bomb_cooldown();
        apply_keys(16'h002C);
        repeat (20) do_frame(1'b0);
        apply_keys(16'h0000);
        apply_keys(16'h2C00);
        repeat (4) do_frame(1'b0);
        apply_keys(16'h0000);
        apply_keys(16'h002C);
        apply_keys(16'h0000);
        repeat (4) do_frame(1'b0);
        apply_keys(16'h2C2C);
    endtask

    task automatic test_simultaneous();
        apply_keys(16'h0000);
        repeat (BC) do_frame(1'b0);
        apply_keys(16'h282C);
    endtask

    task automatic test_pause();
        apply_keys(16'h0029);
        apply_keys(16'h0000);
        checks++;
        if (paused !== 1'b1) begin
            errors++;
            $display("FAIL pause_on got=%b exp=1", paused);
        end
        apply_keys(16'h0052);
        repeat (4) do_frame(1'b0);
        apply_keys(16'h0028);
        apply_keys(16'h5229);
        do_frame(1'b0);
        apply_keys(16'h0052);
    endtask

    task automatic test_reset_mid();
        apply_keys(16'h2C00);
        apply_keys(16'h001A);
        do_frame(1'b1);
        keycode = 16'h002C;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        check_key_response(16'h002C);
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                apply_keys({rand_code(), rand_code()});
            end else begin
                do_frame(1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_resolve();
        test_bomb_cooldown();
        test_simultaneous();
        test_pause();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
